// File: rtl/bit_popcount_stream_if.sv
// Stream bundle for bit_popcount_stream: input beat channel plus result channel.
// The slave modport is the popcount engine; the master modport is whoever feeds
// beats in and consumes results.
interface bit_popcount_stream_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned ACC_W = 16
);
  logic [WIDTH-1:0] data_i;
  logic             data_val_i;
  logic             data_last_i;
  logic             mode_zeros_i;
  logic             accum_i;
  logic             data_ready_o;
  logic [ACC_W-1:0] data_o;
  logic             data_val_o;
  logic             data_ovf_o;
  logic             ready_i;

  modport master (
    output data_i, data_val_i, data_last_i, mode_zeros_i, accum_i, ready_i,
    input  data_ready_o, data_o, data_val_o, data_ovf_o
  );

  modport slave (
    input  data_i, data_val_i, data_last_i, mode_zeros_i, accum_i, ready_i,
    output data_ready_o, data_o, data_val_o, data_ovf_o
  );
endinterface

// File: rtl/bit_popcount_stream.sv
// Pipelined population counter with optional burst accumulation.
// Latency is $clog2(WIDTH/SLICE)+2 enabled cycles: one leaf-count stage, one
// stage per adder-tree level, one accumulate/output stage. The whole pipe
// stalls as a unit while a result is waiting on downstream ready.
module bit_popcount_stream #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 8,
  parameter int unsigned ACC_W = 16
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  bit_popcount_stream_if.slave bus
);

  localparam int unsigned NS   = WIDTH / SLICE;
  localparam int unsigned LV   = $clog2(NS);
  localparam int unsigned CW   = $clog2(WIDTH) + 1;
  localparam int unsigned NN   = 2 * NS - 1;
  localparam int unsigned ROOT = NN - 1;
  localparam int unsigned XW   = ACC_W + 1;

  if ((WIDTH % SLICE) != 0 || (NS & (NS - 1)) != 0 || ACC_W < CW) begin : g_bad_param
    $error("bit_popcount_stream: illegal WIDTH/SLICE/ACC_W combination");
  end

  // Tree nodes are packed level after level: leaves at 0..NS-1, then NS/2
  // nodes of level 1, and so on down to the single root at index NN-1.
  function automatic int unsigned lvl_base(input int unsigned j);
    return 2 * NS - 2 * (NS >> j);
  endfunction

  logic             en;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    leaf [NS];
  logic [CW-1:0]    node_q [NN];
  logic [LV:0]      v_q;
  logic [LV:0]      l_q;
  logic [LV:0]      a_q;

  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic [ACC_W-1:0] out_q;
  logic             out_val_q;
  logic             out_ovf_q;

  logic [XW-1:0]    raw;
  logic             hit;
  logic [ACC_W-1:0] sat;
  logic [ACC_W-1:0] beat_cnt;

  assign en = !out_val_q || bus.ready_i;

  // Per-slice popcount of the (optionally inverted) input word.
  always_comb begin
    word = bus.mode_zeros_i ? ~bus.data_i : bus.data_i;
    for (int unsigned i = 0; i < NS; i++) begin
      leaf[i] = '0;
      for (int unsigned b = 0; b < SLICE; b++) begin
        leaf[i] = leaf[i] + CW'(word[i*SLICE+b]);
      end
    end
  end

  // Leaf stage and adder-tree levels, each carrying valid/last/accum tags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned n = 0; n < NN; n++) node_q[n] <= '0;
      v_q <= '0;
      l_q <= '0;
      a_q <= '0;
    end else if (en) begin
      for (int unsigned i = 0; i < NS; i++) node_q[i] <= leaf[i];
      for (int unsigned j = 1; j <= LV; j++) begin
        for (int unsigned i = 0; i < (NS >> j); i++) begin
          node_q[lvl_base(j)+i] <= node_q[lvl_base(j-1)+2*i] + node_q[lvl_base(j-1)+2*i+1];
        end
      end
      v_q[0] <= bus.data_val_i;
      l_q[0] <= bus.data_last_i;
      a_q[0] <= bus.accum_i;
      for (int unsigned j = 1; j <= LV; j++) begin
        v_q[j] <= v_q[j-1];
        l_q[j] <= l_q[j-1];
        a_q[j] <= a_q[j-1];
      end
    end
  end

  // Saturating add of the tree root onto the running burst sum.
  always_comb begin
    raw      = {1'b0, sum_q} + XW'(node_q[ROOT]);
    hit      = raw[ACC_W];
    sat      = hit ? '1 : raw[ACC_W-1:0];
    beat_cnt = ACC_W'(node_q[ROOT]);
  end

  // Accumulate/output stage: single-beat results bypass the running sum;
  // a closing burst beat emits the sum with its sticky overflow and clears both.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      out_val_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if (en) begin
      out_val_q <= 1'b0;
      if (v_q[LV]) begin
        if (!a_q[LV]) begin
          out_q     <= beat_cnt;
          out_ovf_q <= 1'b0;
          out_val_q <= 1'b1;
        end else if (l_q[LV]) begin
          out_q     <= sat;
          out_ovf_q <= ovf_q | hit;
          out_val_q <= 1'b1;
          sum_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          sum_q <= sat;
          ovf_q <= ovf_q | hit;
        end
      end
    end
  end

  assign bus.data_ready_o = en;
  assign bus.data_o       = out_q;
  assign bus.data_val_o   = out_val_q;
  assign bus.data_ovf_o   = out_ovf_q;

endmodule

// File: doc/bit_popcount_stream.md
BIT_POPCOUNT_STREAM -- requirements
Module: bit_popcount_stream

Interface
REQ-001 Parameter WIDTH, default 64: input word width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 8: leaf slice width; WIDTH/SLICE SHALL be a power of two.
REQ-003 Parameter ACC_W, default 16: result/accumulator width; SHALL be >= $clog2(WIDTH)+1.
REQ-004 Derived constant L = $clog2(WIDTH/SLICE)+2 SHALL define the fixed pipeline latency in cycles (default 5).
REQ-005 clk_i  input  1  single clock; all state on rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-007 data_i  input  WIDTH  input word.
REQ-008 data_val_i  input  1  input beat valid.
REQ-009 data_last_i  input  1  last beat of an accumulation burst; qualified by data_val_i.
REQ-010 mode_zeros_i  input  1  per-beat: 0 = count ones, 1 = count zeros.
REQ-011 accum_i  input  1  per-beat: 1 = add the beat to the running burst sum.
REQ-012 data_ready_o  output  1  beat accepted when data_val_i && data_ready_o.
REQ-013 data_o  output  ACC_W  count result.
REQ-014 data_val_o  output  1  result valid.
REQ-015 data_ovf_o  output  1  result saturated; qualified by data_val_o.
REQ-016 ready_i  input  1  downstream ready; result consumed when data_val_o && ready_i.

Function
REQ-017 Stage 1 SHALL register per-slice popcounts of data_i (or ~data_i when mode_zeros_i=1); each of the next $clog2(WIDTH/SLICE) stages SHALL register one pairwise adder-tree level; the final stage SHALL be the accumulate/output register.
REQ-018 Global enable en = !data_val_o || ready_i; all pipeline, valid, sum and output registers SHALL advance only when en=1.
REQ-019 data_ready_o SHALL equal en (combinational); no beat SHALL be lost, duplicated or reordered under any ready_i pattern.
REQ-020 Each stage SHALL carry valid, last and accum tag bits; bubbles SHALL propagate as invalid stages without compaction.
REQ-021 Accepted beat with accum_i=0: result = beat count, emitted L enabled cycles after acceptance; the running sum SHALL be unaffected.
REQ-022 Accepted beat with accum_i=1, data_last_i=0: beat count added to running sum; no result emitted for that beat.
REQ-023 Accepted beat with accum_i=1, data_last_i=1: result = running sum + beat count, emitted L enabled cycles after acceptance; running sum SHALL clear to 0 in the same cycle.
REQ-024 Running sum SHALL saturate at 2^ACC_W-1; a sticky overflow flag SHALL set on saturation, be output as data_ovf_o with the burst result, then clear with the sum.
REQ-025 data_ovf_o SHALL be 0 for accum_i=0 results.
REQ-026 While data_val_o=1 and ready_i=0, data_o, data_ovf_o and data_val_o SHALL hold stable.
REQ-027 With ready_i held 1 and data_val_i held 1, throughput SHALL be one beat per cycle.
REQ-028 data_last_i with accum_i=0 SHALL be ignored.

Reset
REQ-029 On rst_n_i=0, asynchronously: all stage valids, data_val_o, data_ovf_o, overflow flag = 0; data_o, running sum, all stage data = 0.
REQ-030 An open burst SHALL be discarded by reset; the first post-reset burst SHALL start from sum 0.
REQ-031 After rst_n_i deasserts, data_ready_o SHALL be 1 on the first rising edge.

Verification (WIDTH=64, SLICE=8, ACC_W=16, L=5 unless stated)
REQ-032 Single beat 64'hFFFF_FFFF_FFFF_FFFF, ones, accum_i=0, ready_i=1 -> data_o=64, data_val_o high exactly 1 cycle, 5 cycles after acceptance, data_ovf_o=0.
REQ-033 Beat 64'h0000_0000_0000_000F with mode_zeros_i=1 -> data_o=60; back-to-back beats 64'h1, 64'h3, 64'h7 (ones) -> 1, 2, 3 on consecutive cycles.
REQ-034 Three all-ones beats with accum_i=1, last on the third -> single result 192, 5 cycles after the third beat; no data_val_o for beats 1-2.
REQ-035 Seven back-to-back beats 64'h1..64'h7 (ones) with ready_i low for 10 cycles starting when the first result appears -> data_ready_o=0 while stalled, outputs held; after release results 1,1,2,1,2,2,3 in order, none dropped or repeated.
REQ-036 Build ACC_W=8: five all-ones accum beats, last on the fifth -> data_o=255, data_ovf_o=1; following single-beat burst 64'h3 with last -> data_o=2, data_ovf_o=0.
REQ-037 rst_n_i pulsed low mid-burst after two accum beats of 64'hFF -> data_val_o=0 immediately (asynchronously); post-reset accum beat 64'h1 with last -> data_o=1.
